// File: rtl/mem_rd_arbiter.sv
// Round-robin read-channel arbiter: IFU (m0) and LSU (m1) share one slave read port.
// A grant is held from the address handshake until the read data is taken, one read at a time.
module mem_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RESP_W = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] m0_araddr_i,
  input  logic              m0_arvalid_i,
  output logic              m0_arready_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic [RESP_W-1:0] m0_rresp_o,
  output logic              m0_rvalid_o,
  input  logic              m0_rready_i,

  input  logic [ADDR_W-1:0] m1_araddr_i,
  input  logic              m1_arvalid_i,
  output logic              m1_arready_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [RESP_W-1:0] m1_rresp_o,
  output logic              m1_rvalid_o,
  input  logic              m1_rready_i,

  output logic [ADDR_W-1:0] s_araddr_o,
  output logic              s_arvalid_o,
  input  logic              s_arready_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic [RESP_W-1:0] s_rresp_i,
  input  logic              s_rvalid_i,
  output logic              s_rready_o,

  output logic [1:0]        grant_o
);

  typedef enum logic [2:0] {
    IDLE,
    AR0,
    R0,
    AR1,
    R1
  } state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;

  // last_grant only moves on a completed read, so an abandoned address phase keeps the turn order.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_arvalid_i && m1_arvalid_i) begin
          state_d = last_grant_q ? AR0 : AR1;
        end else if (m0_arvalid_i) begin
          state_d = AR0;
        end else if (m1_arvalid_i) begin
          state_d = AR1;
        end
      end
      AR0: begin
        if (!m0_arvalid_i) begin
          state_d = IDLE;
        end else if (s_arready_i) begin
          state_d = R0;
        end
      end
      R0: begin
        if (s_rvalid_i && m0_rready_i) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end
      AR1: begin
        if (!m1_arvalid_i) begin
          state_d = IDLE;
        end else if (s_arready_i) begin
          state_d = R1;
        end
      end
      R1: begin
        if (s_rvalid_i && m1_rready_i) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Handshakes pass straight through for the owner; everything else is forced to zero.
  always_comb begin
    s_araddr_o   = '0;
    s_arvalid_o  = 1'b0;
    s_rready_o   = 1'b0;
    m0_arready_o = 1'b0;
    m0_rdata_o   = '0;
    m0_rresp_o   = '0;
    m0_rvalid_o  = 1'b0;
    m1_arready_o = 1'b0;
    m1_rdata_o   = '0;
    m1_rresp_o   = '0;
    m1_rvalid_o  = 1'b0;
    grant_o      = 2'b00;
    case (state_q)
      AR0: begin
        grant_o      = 2'b01;
        s_araddr_o   = m0_araddr_i;
        s_arvalid_o  = m0_arvalid_i;
        m0_arready_o = s_arready_i;
      end
      R0: begin
        grant_o     = 2'b01;
        m0_rvalid_o = s_rvalid_i;
        m0_rdata_o  = s_rdata_i;
        m0_rresp_o  = s_rresp_i;
        s_rready_o  = m0_rready_i;
      end
      AR1: begin
        grant_o      = 2'b10;
        s_araddr_o   = m1_araddr_i;
        s_arvalid_o  = m1_arvalid_i;
        m1_arready_o = s_arready_i;
      end
      R1: begin
        grant_o     = 2'b10;
        m1_rvalid_o = s_rvalid_i;
        m1_rdata_o  = s_rdata_i;
        m1_rresp_o  = s_rresp_i;
        s_rready_o  = m1_rready_i;
      end
      default: ;
    endcase
  end

endmodule
